alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencing stage wrapped around the combinational 8-bit ALU.
- Accepts operation commands over a valid/ready handshake and registers the operands and select lines onto the ALU inputs.
- Holds those inputs stable for a settle window, then captures F/c/v/z into a result register and an accumulator.
- Presents the result downstream over a second valid/ready handshake. The ALU itself is instantiated beside this block, not inside it.

Parameters:
- W, 8, datapath width; must match the ALU width.
- EXEC_CYCLES, 1, cycles the ALU inputs are held before sampling (>=1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_sel  input  3  ALU select {s2,s1,s0}; s2=0 arithmetic unit, s2=1 logic unit
- cmd_use_acc  input  1  1: operand A taken from the accumulator; 0: from cmd_a
- cmd_a  input  W  operand A
- cmd_b  input  W  operand B
- cmd_wr_acc  input  1  write result F into the accumulator on capture
- acc_clr  input  1  synchronous accumulator clear
- alu_a, alu_b  output  W  registered operands to the ALU A/B
- alu_s2, alu_s1, alu_s0  output  1  registered select lines to the ALU
- alu_f  input  W  ALU result F
- alu_c, alu_v, alu_z  input  1  ALU flags
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_f  output  W  captured result
- res_c, res_v, res_z  output  1  captured flags
- acc  output  W  accumulator value
- op_count  output  8  completed-operation counter, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, port rst_n.
- Reset values: every output and register is 0 (alu_*, res_*, acc, op_count). State = IDLE, so cmd_ready = 1 and res_valid = 0.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid&cmd_ready at edge k, latch cmd_sel, cmd_b and the A operand (acc if cmd_use_acc, else cmd_a) into the alu_* registers.
  - Latch cmd_wr_acc. Load the settle counter with EXEC_CYCLES-1. Go to EXEC.
- EXEC:
  - cmd_ready = 0. alu_* registers hold stable.
  - The counter decrements each cycle. On the edge where it reads 0 (edge k+EXEC_CYCLES), capture alu_f/c/v/z into res_*.
  - On that same edge: if the latched wr_acc is set, acc <= alu_f. op_count increments. Go to DONE.
- DONE:
  - res_valid = 1 and cmd_ready = 0. res_* hold until res_valid&res_ready.
  - On that handshake edge, res_valid falls and state returns to IDLE. A new command is accepted no earlier than the next cycle.
- Latency and throughput: command accept to res_valid = EXEC_CYCLES cycles. Maximum throughput is one op per EXEC_CYCLES+2 cycles with res_ready held high.
- ALU inputs: alu_* keep their last values in IDLE and DONE (no return to 0).
- Accumulator:
  - acc_clr is honoured in any state and clears acc at the next edge.
  - If acc_clr coincides with an accumulator write-back, acc_clr wins (acc = 0).
  - A command with cmd_use_acc accepted in the same cycle as acc_clr uses the pre-clear acc value.
- Flags: captured exactly as delivered by the ALU, with no masking by unit. c and v are meaningful only when s2=0.
- Inputs ignored: cmd_* are ignored outside the accept handshake; res_ready is ignored outside DONE.
- Reset mid-operation: rst_n low in EXEC or DONE aborts immediately. The pending result is discarded and acc and op_count are cleared.
- Overflow/wrap: op_count wraps modulo 256. There are no other width extensions; W-bit values pass through unchanged.

Decomposition:
- Shared package:
  - state enum IDLE/EXEC/DONE
  - select encodings, 3-bit: arithmetic ops s2=0 (0..3), logic ops s2=1 (4..7)
  - EXEC_CYCLES default constant
- One natural sub-module: alu_settle_timer, a loadable down-counter with a zero flag. Everything else stays in alu_issue_ctrl.
- The ALU is instantiated beside this block and connected at the level above.

Test Plan:
- Reset: rst_n low mid-EXEC -> next cycle cmd_ready=1, res_valid=0, acc=0, op_count=0, alu_a=alu_b=0.
- Basic op: EXEC_CYCLES=1, cmd_a=8'h3C, cmd_b=8'h0F, sel=3'b000, ALU model returns F=8'h4B -> res_valid rises 1 cycle after accept, res_f=8'h4B; with cmd_wr_acc=1, acc=8'h4B.
- Chaining: acc=8'h4B, cmd_use_acc=1, cmd_b=8'hB5, ALU model returns F=8'h00, z=1, c=1 -> alu_a=8'h4B, res_z=1, res_c=1, acc=8'h00.
- Backpressure: res_ready=0 for 5 cycles -> res_valid and res_f stable, cmd_ready=0 throughout; res_ready=1 -> IDLE next cycle.
- Settle/clear: EXEC_CYCLES=3, acc_clr asserted on the capture edge with cmd_wr_acc=1 -> res_valid 3 cycles after accept, acc=0.
- Counter wrap: 256 completed ops -> op_count returns to 8'h00.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue/sequencing stage.
package alu_issue_ctrl_pkg;

   // Sequencer states: waiting for a command, holding ALU inputs, presenting a result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ALU select encodings {s2,s1,s0}: s2=0 arithmetic unit, s2=1 logic unit
   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_SUB = 3'b001;
   localparam logic [2:0] SEL_INC = 3'b010;
   localparam logic [2:0] SEL_DEC = 3'b011;
   localparam logic [2:0] SEL_AND = 3'b100;
   localparam logic [2:0] SEL_OR  = 3'b101;
   localparam logic [2:0] SEL_XOR = 3'b110;
   localparam logic [2:0] SEL_NOT = 3'b111;

   // Default number of cycles the ALU inputs are held before sampling
   localparam int EXEC_CYCLES_DEF = 1;

   // Carry and overflow flags only carry meaning for arithmetic selects
   function automatic logic sel_is_logic(input logic [2:0] sel);
      return sel[2];
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_settle.sv
// Loadable down-counter with a zero flag; times the ALU settle window.
module alu_settle_timer #(
   parameter int CW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_dec,
   output logic [CW-1:0] o_count,
   output logic          o_zero
);

   logic [CW-1:0] r_count;

   // Load takes priority; decrement saturates at zero so the flag stays asserted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencing stage around an external combinational ALU: accepts a command,
// drives registered operands/selects, waits a settle window, captures the
// result and flags, updates the accumulator and hands the result downstream.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int W           = 8,
   parameter int EXEC_CYCLES = EXEC_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   // command interface
   input  logic         i_cmd_valid,
   output logic         o_cmd_ready,
   input  logic [2:0]   i_cmd_sel,
   input  logic         i_cmd_use_acc,
   input  logic [W-1:0] i_cmd_a,
   input  logic [W-1:0] i_cmd_b,
   input  logic         i_cmd_wr_acc,
   input  logic         i_acc_clr,
   // to/from the ALU instantiated alongside
   output logic [W-1:0] o_alu_a,
   output logic [W-1:0] o_alu_b,
   output logic         o_alu_s2,
   output logic         o_alu_s1,
   output logic         o_alu_s0,
   input  logic [W-1:0] i_alu_f,
   input  logic         i_alu_c,
   input  logic         i_alu_v,
   input  logic         i_alu_z,
   // result interface
   output logic         o_res_valid,
   input  logic         i_res_ready,
   output logic [W-1:0] o_res_f,
   output logic         o_res_c,
   output logic         o_res_v,
   output logic         o_res_z,
   output logic [W-1:0] o_acc,
   output logic [7:0]   o_op_count
);

   // Counter wide enough to hold EXEC_CYCLES-1; at least one bit
   localparam int            CW          = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(EXEC_CYCLES - 1);

   state_t         r_state;
   logic           r_cmd_ready;
   logic           r_res_valid;
   logic [W-1:0]   r_alu_a;
   logic [W-1:0]   r_alu_b;
   logic [2:0]     r_alu_sel;
   logic           r_wr_acc;
   logic [W-1:0]   r_res_f;
   logic           r_res_c;
   logic           r_res_v;
   logic           r_res_z;
   logic [W-1:0]   r_acc;
   logic [7:0]     r_op_count;

   logic           w_accept;
   logic           w_in_exec;
   logic           w_timer_zero;
   logic           w_capture;
   logic [CW-1:0]  w_timer_count;

   assign w_accept  = i_cmd_valid & r_cmd_ready;
   assign w_in_exec = (r_state == ST_EXEC);
   assign w_capture = w_in_exec & w_timer_zero;

   // Settle window: loaded on accept, counts down while in EXEC
   alu_settle_timer #(
      .CW (CW)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_load_val (SETTLE_LOAD),
      .i_dec      (w_in_exec & ~w_timer_zero),
      .o_count    (w_timer_count),
      .o_zero     (w_timer_zero)
   );

   // Sequencer FSM with registered handshake outputs, operand and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_res_valid <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_wr_acc    <= 1'b0;
         r_res_f     <= '0;
         r_res_c     <= 1'b0;
         r_res_v     <= 1'b0;
         r_res_z     <= 1'b0;
         r_op_count  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  // A comes from the accumulator as it stands before any same-cycle clear
                  r_alu_a     <= i_cmd_use_acc ? r_acc : i_cmd_a;
                  r_alu_b     <= i_cmd_b;
                  r_alu_sel   <= i_cmd_sel;
                  r_wr_acc    <= i_cmd_wr_acc;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_timer_zero) begin
                  // Flags are taken exactly as the ALU drives them, whatever the unit
                  r_res_f     <= i_alu_f;
                  r_res_c     <= i_alu_c;
                  r_res_v     <= i_alu_v;
                  r_res_z     <= i_alu_z;
                  r_op_count  <= r_op_count + 8'd1;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_res_ready) begin
                  // Ready rises with the return to IDLE, so the next accept is a cycle later
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Accumulator: clear in any state beats a write-back on the capture edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_acc_clr) begin
         r_acc <= '0;
      end else if (w_capture && r_wr_acc) begin
         r_acc <= i_alu_f;
      end
   end

   assign o_cmd_ready = r_cmd_ready;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_s2    = r_alu_sel[2];
   assign o_alu_s1    = r_alu_sel[1];
   assign o_alu_s0    = r_alu_sel[0];
   assign o_res_valid = r_res_valid;
   assign o_res_f     = r_res_f;
   assign o_res_c     = r_res_c;
   assign o_res_v     = r_res_v;
   assign o_res_z     = r_res_z;
   assign o_acc       = r_acc;
   assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: instance 0 uses a 1-cycle settle window,
// instance 1 a 3-cycle window. A behavioural ALU sits beside each instance.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   typedef struct packed {
      logic [7:0] f;
      logic       c;
      logic       v;
      logic       z;
   } alu_out_t;

   typedef struct packed {
      logic       use_acc;
      logic [2:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic       wr;
      logic [3:0] hold;
      logic [7:0] f;
      logic       c;
      logic       v;
      logic       z;
      logic [7:0] exp_alu_a;
      logic [7:0] exp_acc;
   } vec_t;

   typedef struct packed {
      logic [7:0] f;
      logic       c;
      logic       v;
      logic       z;
      logic [7:0] alu_a;
      logic [7:0] acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid   [2];
   logic       cmd_ready   [2];
   logic [2:0] cmd_sel     [2];
   logic       cmd_use_acc [2];
   logic [7:0] cmd_a       [2];
   logic [7:0] cmd_b       [2];
   logic       cmd_wr_acc  [2];
   logic       acc_clr     [2];
   logic [7:0] alu_a       [2];
   logic [7:0] alu_b       [2];
   logic       alu_s2      [2];
   logic       alu_s1      [2];
   logic       alu_s0      [2];
   logic       res_valid   [2];
   logic       res_ready   [2];
   logic [7:0] res_f       [2];
   logic       res_c       [2];
   logic       res_v       [2];
   logic       res_z       [2];
   logic [7:0] acc         [2];
   logic [7:0] op_count    [2];

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   // Behavioural ALU: c is carry-out (no-borrow for SUB), v signed overflow
   function automatic alu_out_t alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      alu_out_t   r;
      logic [8:0] t;
      r = '0;
      t = '0;
      case (s)
         SEL_ADD: begin t = {1'b0, a} + {1'b0, b};        r.f = t[7:0]; r.c = t[8]; r.v = (a[7] == b[7]) && (r.f[7] != a[7]); end
         SEL_SUB: begin t = {1'b0, a} + {1'b0, ~b} + 9'd1; r.f = t[7:0]; r.c = t[8]; r.v = (a[7] != b[7]) && (r.f[7] != a[7]); end
         SEL_INC: begin t = {1'b0, a} + 9'd1;             r.f = t[7:0]; r.c = t[8]; r.v = (a == 8'h7F); end
         SEL_DEC: begin t = {1'b0, a} + 9'h0FF;           r.f = t[7:0]; r.c = t[8]; r.v = (a == 8'h80); end
         SEL_AND: r.f = a & b;
         SEL_OR:  r.f = a | b;
         SEL_XOR: r.f = a ^ b;
         default: r.f = ~a;
      endcase
      r.z = (r.f == 8'h00);
      return r;
   endfunction

   function automatic int ec_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      alu_out_t m;
      assign m = alu_fn(alu_a[gi], alu_b[gi], {alu_s2[gi], alu_s1[gi], alu_s0[gi]});

      alu_issue_ctrl #(
         .W           (8),
         .EXEC_CYCLES ((gi == 0) ? 1 : 3)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .i_cmd_valid   (cmd_valid[gi]),
         .o_cmd_ready   (cmd_ready[gi]),
         .i_cmd_sel     (cmd_sel[gi]),
         .i_cmd_use_acc (cmd_use_acc[gi]),
         .i_cmd_a       (cmd_a[gi]),
         .i_cmd_b       (cmd_b[gi]),
         .i_cmd_wr_acc  (cmd_wr_acc[gi]),
         .i_acc_clr     (acc_clr[gi]),
         .o_alu_a       (alu_a[gi]),
         .o_alu_b       (alu_b[gi]),
         .o_alu_s2      (alu_s2[gi]),
         .o_alu_s1      (alu_s1[gi]),
         .o_alu_s0      (alu_s0[gi]),
         .i_alu_f       (m.f),
         .i_alu_c       (m.c),
         .i_alu_v       (m.v),
         .i_alu_z       (m.z),
         .o_res_valid   (res_valid[gi]),
         .i_res_ready   (res_ready[gi]),
         .o_res_f       (res_f[gi]),
         .o_res_c       (res_c[gi]),
         .o_res_v       (res_v[gi]),
         .o_res_z       (res_z[gi]),
         .o_acc         (acc[gi]),
         .o_op_count    (op_count[gi])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on each result handshake
   always @(negedge clk) begin : mon
      exp_t e;
      bit   have;
      for (int d = 0; d < 2; d++) begin
         if (rst_n && res_valid[d] && res_ready[d]) begin
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
               chk("unexpected_result", 32'(d), 32'hFFFF);
            end else begin
               chk("res_f", 32'(res_f[d]), 32'(e.f));
               chk("res_c", 32'(res_c[d]), 32'(e.c));
               chk("res_v", 32'(res_v[d]), 32'(e.v));
               chk("res_z", 32'(res_z[d]), 32'(e.z));
               chk("alu_a_held", 32'(alu_a[d]), 32'(e.alu_a));
               chk("acc", 32'(acc[d]), 32'(e.acc));
               $display("txn dut%0d: f=%02h c=%0b v=%0b z=%0b acc=%02h", d, res_f[d], res_c[d], res_v[d], res_z[d], acc[d]);
            end
         end
      end
   end

   // Issue one command; clr_at: -1 none, 0 in accept cycle, N on the Nth edge after accept
   task automatic do_cmd(input int d, input vec_t v, input int clr_at, input bit push);
      exp_t e;
      int   lat;
      int   guard;
      @(negedge clk);
      cmd_valid[d]   = 1'b1;
      cmd_sel[d]     = v.sel;
      cmd_use_acc[d] = v.use_acc;
      cmd_a[d]       = v.a;
      cmd_b[d]       = v.b;
      cmd_wr_acc[d]  = v.wr;
      if (clr_at == 0) acc_clr[d] = 1'b1;
      guard = 0;
      while (!cmd_ready[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready[d]) begin
         chk("cmd_ready_timeout", 32'(cmd_ready[d]), 32'd1);
         cmd_valid[d] = 1'b0;
         acc_clr[d]   = 1'b0;
         return;
      end
      @(posedge clk);
      e = '{f: v.f, c: v.c, v: v.v, z: v.z, alu_a: v.exp_alu_a, acc: v.exp_acc};
      if (push) begin
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      #1;
      // Junk on the command bus must be ignored from here on
      cmd_valid[d]   = 1'b0;
      acc_clr[d]     = 1'b0;
      cmd_a[d]       = ~v.a;
      cmd_b[d]       = ~v.b;
      cmd_sel[d]     = ~v.sel;
      cmd_use_acc[d] = ~v.use_acc;
      cmd_wr_acc[d]  = ~v.wr;
      if (!push) return;
      lat = 0;
      while (!res_valid[d] && lat < 20) begin
         chk("exec_cmd_ready", 32'(cmd_ready[d]), 32'd0);
         if (lat + 1 == clr_at) acc_clr[d] = 1'b1;
         @(posedge clk);
         #1;
         acc_clr[d] = 1'b0;
         lat++;
      end
      chk("latency", 32'(lat), 32'(ec_of(d)));
      chk("alu_a", 32'(alu_a[d]), 32'(v.exp_alu_a));
      chk("alu_b", 32'(alu_b[d]), 32'(v.b));
      chk("alu_sel", 32'({alu_s2[d], alu_s1[d], alu_s0[d]}), 32'(v.sel));
      if (v.hold != 0) cmd_valid[d] = 1'b1;
      for (int i = 0; i < int'(v.hold); i++) begin
         @(posedge clk);
         #1;
         chk("bp_res_valid", 32'(res_valid[d]), 32'd1);
         chk("bp_res_f", 32'(res_f[d]), 32'(v.f));
         chk("bp_cmd_ready", 32'(cmd_ready[d]), 32'd0);
      end
      cmd_valid[d] = 1'b0;
      res_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      res_ready[d] = 1'b0;
      chk("res_valid_drop", 32'(res_valid[d]), 32'd0);
      chk("back_to_idle", 32'(cmd_ready[d]), 32'd1);
   endtask

   // Hand-computed vectors: {use_acc, sel, a, b, wr, hold, f, c, v, z, alu_a, acc}
   vec_t vt0 [10];
   vec_t vt1 [4];

   initial begin
      vec_t vz;
      vec_t va;
      vec_t vb;
      vt0[0] = '{1'b0, SEL_ADD, 8'h3C, 8'h0F, 1'b1, 4'd0, 8'h4B, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h4B};
      vt0[1] = '{1'b1, SEL_ADD, 8'h00, 8'hB5, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4B, 8'h00};
      vt0[2] = '{1'b0, SEL_XOR, 8'h55, 8'hAA, 1'b0, 4'd5, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00};
      vt0[3] = '{1'b0, SEL_SUB, 8'h10, 8'h20, 1'b1, 4'd0, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h10, 8'hF0};
      vt0[4] = '{1'b0, SEL_INC, 8'h7F, 8'h00, 1'b0, 4'd0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h7F, 8'hF0};
      vt0[5] = '{1'b1, SEL_DEC, 8'h00, 8'h00, 1'b1, 4'd1, 8'hEF, 1'b1, 1'b0, 1'b0, 8'hF0, 8'hEF};
      vt0[6] = '{1'b0, SEL_AND, 8'hF0, 8'h0F, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF0, 8'hEF};
      vt0[7] = '{1'b0, SEL_OR,  8'hA0, 8'h05, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA0, 8'hEF};
      vt0[8] = '{1'b0, SEL_NOT, 8'hFF, 8'h00, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00};
      vt0[9] = '{1'b0, SEL_ADD, 8'h80, 8'h80, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h80, 8'h00};
      vt1[0] = '{1'b0, SEL_ADD, 8'h20, 8'h22, 1'b1, 4'd0, 8'h42, 1'b0, 1'b0, 1'b0, 8'h20, 8'h42};
      vt1[1] = '{1'b0, SEL_ADD, 8'h01, 8'h02, 1'b1, 4'd0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00};
      vt1[2] = '{1'b0, SEL_ADD, 8'h05, 8'h00, 1'b1, 4'd0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05, 8'h05};
      vt1[3] = '{1'b1, SEL_ADD, 8'hEE, 8'h01, 1'b0, 4'd0, 8'h06, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00};
      vz     = '{1'b0, SEL_AND, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      va     = '{1'b0, SEL_ADD, 8'h12, 8'h34, 1'b1, 4'd0, 8'h46, 1'b0, 1'b0, 1'b0, 8'h12, 8'h46};
      vb     = '{1'b0, SEL_ADD, 8'h77, 8'h11, 1'b1, 4'd0, 8'h88, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0; cmd_sel[d] = '0; cmd_use_acc[d] = 1'b0; cmd_a[d] = '0;
         cmd_b[d] = '0; cmd_wr_acc[d] = 1'b0; acc_clr[d] = 1'b0; res_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
         chk("rst_res_valid", 32'(res_valid[d]), 32'd0);
         chk("rst_acc", 32'(acc[d]), 32'd0);
         chk("rst_op_count", 32'(op_count[d]), 32'd0);
         chk("rst_alu_a", 32'(alu_a[d]), 32'd0);
      end

      // Directed operations, 1-cycle settle window
      for (int i = 0; i < 10; i++) do_cmd(0, vt0[i], -1, 1'b1);
      chk("op_count_10", 32'(op_count[0]), 32'd10);

      // Settle window of 3, clears on the capture edge and on the accept edge
      do_cmd(1, vt1[0], -1, 1'b1);
      do_cmd(1, vt1[1],  3, 1'b1);
      do_cmd(1, vt1[2], -1, 1'b1);
      do_cmd(1, vt1[3],  0, 1'b1);
      chk("dut1_op_count", 32'(op_count[1]), 32'd4);

      // Fill op_count up to 256 completed operations
      for (int i = 0; i < 246; i++) do_cmd(0, vz, -1, 1'b1);
      chk("op_count_wrap", 32'(op_count[0]), 32'd0);

      // Reset in the middle of EXEC
      do_cmd(0, va, -1, 1'b1);
      chk("pre_rst_acc", 32'(acc[0]), 32'h46);
      chk("pre_rst_op_count", 32'(op_count[0]), 32'd1);
      do_cmd(0, vb, -1, 1'b0);
      chk("pre_rst_in_exec", 32'(cmd_ready[0]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_acc", 32'(acc[0]), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_cmd_ready", 32'(cmd_ready[0]), 32'd1);
      chk("abort_res_valid", 32'(res_valid[0]), 32'd0);
      chk("abort_acc", 32'(acc[0]), 32'd0);
      chk("abort_op_count", 32'(op_count[0]), 32'd0);
      chk("abort_alu_a", 32'(alu_a[0]), 32'd0);
      chk("abort_alu_b", 32'(alu_b[0]), 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_no_result", 32'(res_valid[0]), 32'd0);
      chk("sb0_empty", 32'(q0.size()), 32'd0);
      chk("sb1_empty", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
